// File: rtl/modport_fifo_pkg.sv
// Shared constants and types for the modport_fifo slice.
package modport_fifo_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 3;
    localparam int unsigned WORD_WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;

    // Pointer with one extra wrap bit above the index bits.
    typedef logic [ADDR_WIDTH_DEF:0] ptr_t;

endpackage

// File: rtl/modport_fifo_if.sv
// Producer/consumer handshake bundle for modport_fifo.
interface modport_fifo_if
    import modport_fifo_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
);

    logic                  push;
    logic                  pull;
    logic [WORD_WIDTH-1:0] din;
    logic [WORD_WIDTH-1:0] dout;
    logic                  empty;
    logic                  full;

    // Request side, as seen by whoever drives the FIFO.
    modport master (
        output push, pull, din,
        input  dout, empty, full
    );

    // FIFO side.
    modport slave (
        input  push, pull, din,
        output dout, empty, full
    );

    // Passive observer of every signal.
    modport monitor (
        input push, pull, din, dout, empty, full
    );

endinterface

// File: rtl/modport_fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered synchronous read.
module modport_fifo_mem
    import modport_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WORD_WIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [WORD_WIDTH-1:0] mem [DEPTH];

    // Storage array is never cleared; stale words are unreachable after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register holds its value until the next accepted read.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/modport_fifo.sv
// Single-clock FIFO: pointer bookkeeping, accept logic and flag decode.
module modport_fifo
    import modport_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         res,
    modport_fifo_if.slave bus
);

    localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr_nxt;
    logic [PTR_WIDTH-1:0] rd_ptr_nxt;
    logic                 push_ok_c;
    logic                 pull_ok_c;

    // Flags come straight from the pointer registers, never from push/pull.
    assign bus.empty = (wr_ptr == rd_ptr);
    assign bus.full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                       (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

    // Accept decisions and next pointer values; nothing is accepted during reset.
    always_comb begin
        push_ok_c  = 1'b0;
        pull_ok_c  = 1'b0;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (!res) begin
            push_ok_c = bus.push && !bus.full;
            pull_ok_c = bus.pull && !bus.empty;
        end
        if (push_ok_c) begin
            wr_ptr_nxt = wr_ptr + PTR_WIDTH'(1);
        end
        if (pull_ok_c) begin
            rd_ptr_nxt = rd_ptr + PTR_WIDTH'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    modport_fifo_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_mem (
        .clk   (clk),
        .res   (res),
        .we    (push_ok_c),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (bus.din),
        .re    (pull_ok_c),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (bus.dout)
    );

endmodule

// File: tb/tb_modport_fifo.sv
// Scoreboard bench for modport_fifo.
module tb_modport_fifo;
    import modport_fifo_pkg::*;

    localparam int unsigned DEPTH = DEPTH_DEF;

    logic clk = 1'b0;
    logic res;

    always #5 clk = ~clk;

    modport_fifo_if bus ();

    modport_fifo dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    logic [7:0] sb [$];
    logic [7:0] exp_dout;
    int         chk;
    int         err;

    // One clock of stimulus; the reference queue tracks what the FIFO should accept.
    task automatic drive(input logic p, input logic q, input logic [7:0] d);
        logic acc_push;
        logic acc_pull;
        bus.push = p;
        bus.pull = q;
        bus.din  = d;
        acc_pull = q && (sb.size() != 0) && !res;
        acc_push = p && (sb.size() != DEPTH) && !res;
        @(posedge clk);
        if (acc_pull) exp_dout = sb.pop_front();
        if (acc_push) sb.push_back(d);
        #2;
        bus.push = 1'b0;
        bus.pull = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        chk++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.dout !== 8'h00) begin
            err++;
            $display("FAIL reset_initial empty=%b full=%b dout=%h required 1 0 00", bus.empty, bus.full, bus.dout);
        end
        @(posedge clk);
        #2;
        res = 1'b0;
        drive(1'b1, 1'b0, 8'h11);
        drive(1'b1, 1'b0, 8'h22);
        drive(1'b1, 1'b0, 8'h33);
        drive(1'b0, 1'b1, 8'h00);
        chk++;
        if (bus.dout !== 8'h11 || bus.empty !== 1'b0) begin
            err++;
            $display("FAIL reset_prestream dout=%h empty=%b required 11 0", bus.dout, bus.empty);
        end
        res = 1'b1;
        #1;
        sb.delete();
        exp_dout = 8'h00;
        chk++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.dout !== 8'h00) begin
            err++;
            $display("FAIL reset_midstream empty=%b full=%b dout=%h required 1 0 00", bus.empty, bus.full, bus.dout);
        end
        drive(1'b1, 1'b0, 8'h44);
        res = 1'b0;
        drive(1'b0, 1'b1, 8'h00);
        chk++;
        if (bus.dout !== 8'h00 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            err++;
            $display("FAIL reset_pull_after dout=%h empty=%b full=%b required 00 1 0", bus.dout, bus.empty, bus.full);
        end
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, 8'(i));
            chk++;
            if (bus.full !== (i == 8) || bus.empty !== 1'b0) begin
                err++;
                $display("FAIL fill_flags n=%0d empty=%b full=%b required 0 %b", i, bus.empty, bus.full, i == 8);
            end
        end
        drive(1'b1, 1'b0, 8'h09);
        chk++;
        if (bus.full !== 1'b1 || bus.dout !== exp_dout) begin
            err++;
            $display("FAIL overflow full=%b dout=%h required 1 %h", bus.full, bus.dout, exp_dout);
        end
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            chk++;
            if (bus.dout !== exp_dout || bus.dout !== 8'(i) || bus.full !== 1'b0 || bus.empty !== (i == 8)) begin
                err++;
                $display("FAIL drain n=%0d dout=%h empty=%b full=%b required %h %b 0", i, bus.dout, bus.empty, bus.full, 8'(i), i == 8);
            end
        end
    endtask

    task automatic test_underflow;
        drive(1'b0, 1'b1, 8'h00);
        chk++;
        if (bus.dout !== 8'h08 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            err++;
            $display("FAIL underflow dout=%h empty=%b full=%b required 08 1 0", bus.dout, bus.empty, bus.full);
        end
        drive(1'b1, 1'b0, 8'hA5);
        chk++;
        if (bus.empty !== 1'b0 || bus.dout !== 8'h08) begin
            err++;
            $display("FAIL underflow_push empty=%b dout=%h required 0 08", bus.empty, bus.dout);
        end
        drive(1'b0, 1'b1, 8'h00);
        chk++;
        if (bus.dout !== 8'hA5 || bus.dout !== exp_dout || bus.empty !== 1'b1) begin
            err++;
            $display("FAIL underflow_pull dout=%h empty=%b required a5 1", bus.dout, bus.empty);
        end
    endtask

    task automatic test_simul_mid;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 8'(8'h40 + i));
            chk++;
            if (bus.dout !== exp_dout || bus.empty !== 1'b0 || bus.full !== 1'b0 || sb.size() != 4) begin
                err++;
                $display("FAIL simul_mid n=%0d dout=%h empty=%b full=%b required %h 0 0", i, bus.dout, bus.empty, bus.full, exp_dout);
            end
        end
        chk++;
        if (bus.dout !== 8'h40) begin
            err++;
            $display("FAIL simul_mid_order dout=%h required 40", bus.dout);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            chk++;
            if (bus.dout !== exp_dout || bus.empty !== (i == 3)) begin
                err++;
                $display("FAIL simul_mid_drain n=%0d dout=%h empty=%b required %h %b", i, bus.dout, bus.empty, exp_dout, i == 3);
            end
        end
    endtask

    task automatic test_simul_boundary;
        drive(1'b1, 1'b1, 8'h50);
        chk++;
        if (bus.dout !== 8'h44 || bus.empty !== 1'b0 || bus.full !== 1'b0) begin
            err++;
            $display("FAIL simul_empty dout=%h empty=%b full=%b required 44 0 0", bus.dout, bus.empty, bus.full);
        end
        for (int i = 1; i < 8; i++) drive(1'b1, 1'b0, 8'(8'h50 + i));
        chk++;
        if (bus.full !== 1'b1) begin
            err++;
            $display("FAIL simul_full_setup full=%b required 1", bus.full);
        end
        drive(1'b1, 1'b1, 8'hEE);
        chk++;
        if (bus.dout !== 8'h50 || bus.full !== 1'b0 || bus.empty !== 1'b0) begin
            err++;
            $display("FAIL simul_full dout=%h full=%b empty=%b required 50 0 0", bus.dout, bus.full, bus.empty);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            chk++;
            if (bus.dout !== exp_dout || bus.dout === 8'hEE || bus.empty !== (i >= 6)) begin
                err++;
                $display("FAIL simul_full_drain n=%0d dout=%h empty=%b required %h %b", i, bus.dout, bus.empty, exp_dout, i >= 6);
            end
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 20; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            chk++;
            if (bus.dout !== exp_dout || bus.empty !== (sb.size() == 0) || bus.full !== (sb.size() == DEPTH)) begin
                err++;
                $display("FAIL wrap n=%0d dout=%h empty=%b full=%b required %h %b %b", i, bus.dout, bus.empty, bus.full,
                         exp_dout, sb.size() == 0, sb.size() == DEPTH);
            end
        end
    endtask

    initial begin
        chk      = 0;
        err      = 0;
        exp_dout = 8'h00;
        res      = 1'b1;
        bus.push = 1'b0;
        bus.pull = 1'b0;
        bus.din  = 8'h00;
        test_reset();
        test_fill();
        test_underflow();
        test_simul_mid();
        test_simul_boundary();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
